// File: rtl/pcie_tx_pkg.sv
// Shared types and arbitration helpers for the PCIe TX arbiter.
package pcie_tx_pkg;

    localparam int NUM_TX_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } tx_arb_state_t;

    typedef logic tx_port_t;

    // Only meaningful when at least one request bit is set.
    function automatic tx_port_t arb_pick(input logic [1:0] req, input tx_port_t rr_last);
        if (req == 2'b11) begin
            return ~rr_last;
        end
        return req[1];
    endfunction

    function automatic tx_arb_state_t port_state(input tx_port_t p);
        return p ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/pcie_tx_axis_mux.sv
// Combinational 2:1 AXI-Stream mux with tready steering, driven by the arbiter state.
module pcie_tx_axis_mux
    import pcie_tx_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  tx_arb_state_t           i_state,
    input  logic [C_DATA_WIDTH-1:0] i_s0_tdata,
    input  logic [KEEP_WIDTH-1:0]   i_s0_tkeep,
    input  logic [3:0]              i_s0_tuser,
    input  logic                    i_s0_tlast,
    input  logic                    i_s0_tvalid,
    input  logic [C_DATA_WIDTH-1:0] i_s1_tdata,
    input  logic [KEEP_WIDTH-1:0]   i_s1_tkeep,
    input  logic [3:0]              i_s1_tuser,
    input  logic                    i_s1_tlast,
    input  logic                    i_s1_tvalid,
    input  logic                    i_m_tready,
    output logic [C_DATA_WIDTH-1:0] o_m_tdata,
    output logic [KEEP_WIDTH-1:0]   o_m_tkeep,
    output logic [3:0]              o_m_tuser,
    output logic                    o_m_tlast,
    output logic                    o_m_tvalid,
    output logic                    o_s0_tready,
    output logic                    o_s1_tready
);

    always_comb begin
        o_m_tdata   = '0;
        o_m_tkeep   = '0;
        o_m_tuser   = '0;
        o_m_tlast   = 1'b0;
        o_m_tvalid  = 1'b0;
        o_s0_tready = 1'b0;
        o_s1_tready = 1'b0;
        case (i_state)
            GNT0: begin
                o_m_tdata   = i_s0_tdata;
                o_m_tkeep   = i_s0_tkeep;
                o_m_tuser   = i_s0_tuser;
                o_m_tlast   = i_s0_tlast;
                o_m_tvalid  = i_s0_tvalid;
                o_s0_tready = i_m_tready;
            end
            GNT1: begin
                o_m_tdata   = i_s1_tdata;
                o_m_tkeep   = i_s1_tkeep;
                o_m_tuser   = i_s1_tuser;
                o_m_tlast   = i_s1_tlast;
                o_m_tvalid  = i_s1_tvalid;
                o_s1_tready = i_m_tready;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the 7-series PCIe TX stream between
// two requesters, with an idle watchdog and link-down release.
module pcie_tx_arbiter
    import pcie_tx_pkg::*;
#(
    parameter int C_DATA_WIDTH   = 64,
    parameter int KEEP_WIDTH     = C_DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    user_clk,
    input  logic                    user_reset_n,
    input  logic                    user_lnk_up,
    input  logic [1:0]              req_i,
    output logic [1:0]              ack_o,
    input  logic [C_DATA_WIDTH-1:0] s0_tdata,
    input  logic [KEEP_WIDTH-1:0]   s0_tkeep,
    input  logic [3:0]              s0_tuser,
    input  logic                    s0_tlast,
    input  logic                    s0_tvalid,
    output logic                    s0_tready,
    input  logic [C_DATA_WIDTH-1:0] s1_tdata,
    input  logic [KEEP_WIDTH-1:0]   s1_tkeep,
    input  logic [3:0]              s1_tuser,
    input  logic                    s1_tlast,
    input  logic                    s1_tvalid,
    output logic                    s1_tready,
    output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
    output logic [3:0]              s_axis_tx_tuser,
    output logic                    s_axis_tx_tlast,
    output logic                    s_axis_tx_tvalid,
    input  logic                    s_axis_tx_tready,
    output logic [CNT_WIDTH-1:0]    pkt_cnt0_o,
    output logic [CNT_WIDTH-1:0]    pkt_cnt1_o,
    output logic [15:0]             timeout_cnt_o
);

    localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    tx_arb_state_t          r_state;
    tx_port_t               r_rr_last;
    logic                   r_in_pkt;
    logic [15:0]            r_idle_cnt;
    logic [15:0]            r_timeout_cnt;
    logic [CNT_WIDTH-1:0]   r_pkt_cnt0;
    logic [CNT_WIDTH-1:0]   r_pkt_cnt1;

    tx_port_t               w_cur;
    logic                   w_cur_req;
    logic                   w_beat;
    logic                   w_tlast_beat;

    assign w_cur        = (r_state == GNT1);
    assign w_cur_req    = req_i[w_cur];
    assign w_beat       = s_axis_tx_tvalid & s_axis_tx_tready;
    assign w_tlast_beat = w_beat & s_axis_tx_tlast;

    pcie_tx_axis_mux #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .KEEP_WIDTH   (KEEP_WIDTH)
    ) u_mux (
        .i_state     (r_state),
        .i_s0_tdata  (s0_tdata),
        .i_s0_tkeep  (s0_tkeep),
        .i_s0_tuser  (s0_tuser),
        .i_s0_tlast  (s0_tlast),
        .i_s0_tvalid (s0_tvalid),
        .i_s1_tdata  (s1_tdata),
        .i_s1_tkeep  (s1_tkeep),
        .i_s1_tuser  (s1_tuser),
        .i_s1_tlast  (s1_tlast),
        .i_s1_tvalid (s1_tvalid),
        .i_m_tready  (s_axis_tx_tready),
        .o_m_tdata   (s_axis_tx_tdata),
        .o_m_tkeep   (s_axis_tx_tkeep),
        .o_m_tuser   (s_axis_tx_tuser),
        .o_m_tlast   (s_axis_tx_tlast),
        .o_m_tvalid  (s_axis_tx_tvalid),
        .o_s0_tready (s0_tready),
        .o_s1_tready (s1_tready)
    );

    // Release priority while granted: link down, end of packet, watchdog, withdrawal.
    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            r_state       <= IDLE;
            r_rr_last     <= 1'b1;
            r_in_pkt      <= 1'b0;
            r_idle_cnt    <= '0;
            r_timeout_cnt <= '0;
            r_pkt_cnt0    <= '0;
            r_pkt_cnt1    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (user_lnk_up && (req_i != 2'b00)) begin
                        r_state    <= port_state(arb_pick(req_i, r_rr_last));
                        r_in_pkt   <= 1'b0;
                        r_idle_cnt <= '0;
                    end
                end
                GNT0, GNT1: begin
                    if (!user_lnk_up) begin
                        r_state  <= IDLE;
                        r_in_pkt <= 1'b0;
                    end else if (w_tlast_beat) begin
                        r_rr_last  <= w_cur;
                        r_in_pkt   <= 1'b0;
                        r_idle_cnt <= '0;
                        if (w_cur) begin
                            r_pkt_cnt1 <= r_pkt_cnt1 + CNT_WIDTH'(1);
                        end else begin
                            r_pkt_cnt0 <= r_pkt_cnt0 + CNT_WIDTH'(1);
                        end
                        if (req_i != 2'b00) begin
                            r_state <= port_state(arb_pick(req_i, w_cur));
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_beat) begin
                        r_in_pkt   <= 1'b1;
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == IDLE_LIMIT) begin
                        r_state   <= IDLE;
                        r_in_pkt  <= 1'b0;
                        r_rr_last <= w_cur;
                        if (r_timeout_cnt != 16'hFFFF) begin
                            r_timeout_cnt <= r_timeout_cnt + 16'd1;
                        end
                    end else if (!r_in_pkt && !w_cur_req) begin
                        r_state <= IDLE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack_o         = {r_state == GNT1, r_state == GNT0};
    assign pkt_cnt0_o    = r_pkt_cnt0;
    assign pkt_cnt1_o    = r_pkt_cnt1;
    assign timeout_cnt_o = r_timeout_cnt;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter: three instances share stimulus and differ only in
// TIMEOUT_CYCLES (1024, 8, 4).
module tb_pcie_tx_arbiter;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst_n;
    logic        lnk;
    logic [1:0]  req;
    logic [63:0] s0_tdata, s1_tdata;
    logic [7:0]  s0_tkeep, s1_tkeep;
    logic [3:0]  s0_tuser, s1_tuser;
    logic        s0_tlast, s1_tlast;
    logic        s0_tvalid, s1_tvalid;
    logic        tready;

    logic [1:0]  ack       [NDUT];
    logic        s0_tready [NDUT];
    logic        s1_tready [NDUT];
    logic [63:0] m_tdata   [NDUT];
    logic [7:0]  m_tkeep   [NDUT];
    logic [3:0]  m_tuser   [NDUT];
    logic        m_tlast   [NDUT];
    logic        m_tvalid  [NDUT];
    logic [31:0] pkt0      [NDUT];
    logic [31:0] pkt1      [NDUT];
    logic [15:0] tmo       [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pcie_tx_arbiter #(
            .C_DATA_WIDTH   (64),
            .KEEP_WIDTH     (8),
            .TIMEOUT_CYCLES ((g == 0) ? 1024 : ((g == 1) ? 8 : 4)),
            .CNT_WIDTH      (32)
        ) u_dut (
            .user_clk         (clk),
            .user_reset_n     (rst_n),
            .user_lnk_up      (lnk),
            .req_i            (req),
            .ack_o            (ack[g]),
            .s0_tdata         (s0_tdata),
            .s0_tkeep         (s0_tkeep),
            .s0_tuser         (s0_tuser),
            .s0_tlast         (s0_tlast),
            .s0_tvalid        (s0_tvalid),
            .s0_tready        (s0_tready[g]),
            .s1_tdata         (s1_tdata),
            .s1_tkeep         (s1_tkeep),
            .s1_tuser         (s1_tuser),
            .s1_tlast         (s1_tlast),
            .s1_tvalid        (s1_tvalid),
            .s1_tready        (s1_tready[g]),
            .s_axis_tx_tdata  (m_tdata[g]),
            .s_axis_tx_tkeep  (m_tkeep[g]),
            .s_axis_tx_tuser  (m_tuser[g]),
            .s_axis_tx_tlast  (m_tlast[g]),
            .s_axis_tx_tvalid (m_tvalid[g]),
            .s_axis_tx_tready (tready),
            .pkt_cnt0_o       (pkt0[g]),
            .pkt_cnt1_o       (pkt1[g]),
            .timeout_cnt_o    (tmo[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = 2'b00;
        lnk       = 1'b1;
        tready    = 1'b1;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        s0_tlast  = 1'b0;
        s1_tlast  = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        lnk       = 1'b1;
        req       = 2'b11;
        tready    = 1'b1;
        s0_tdata  = 64'h1111;
        s1_tdata  = 64'h2222;
        s0_tkeep  = 8'hFF;
        s1_tkeep  = 8'h0F;
        s0_tuser  = 4'h3;
        s1_tuser  = 4'h5;
        s0_tlast  = 1'b0;
        s1_tlast  = 1'b0;
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;

        // Reset with both ports requesting
        repeat (5) cyc();
        check_eq("rst_ack",    64'(ack[0]),      64'h0);
        check_eq("rst_tvalid", 64'(m_tvalid[0]), 64'h0);
        check_eq("rst_tdata",  m_tdata[0],       64'h0);
        check_eq("rst_s0rdy",  64'(s0_tready[0]), 64'h0);
        check_eq("rst_pkt0",   64'(pkt0[0]),     64'h0);
        check_eq("rst_pkt1",   64'(pkt1[0]),     64'h0);
        check_eq("rst_tmo",    64'(tmo[0]),      64'h0);
        rst_n     = 1'b1;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        #1;
        check_eq("rel_ack_idle", 64'(ack[0]), 64'h0);
        cyc();
        check_eq("rel_ack_p0", 64'(ack[0]), 64'h1);

        // Single 3-beat packet on port 0
        for (int k = 0; k < 3; k++) begin
            req       = (k == 2) ? 2'b00 : 2'b01;
            s0_tvalid = 1'b1;
            s0_tdata  = 64'hD000 + 64'(k);
            s0_tlast  = (k == 2);
            #1;
            check_eq("sp_ack",    64'(ack[0]),       64'h1);
            check_eq("sp_tvalid", 64'(m_tvalid[0]),  64'h1);
            check_eq("sp_tdata",  m_tdata[0],        64'hD000 + 64'(k));
            check_eq("sp_tlast",  64'(m_tlast[0]),   64'(k == 2));
            check_eq("sp_s0rdy",  64'(s0_tready[0]), 64'h1);
            check_eq("sp_s1rdy",  64'(s1_tready[0]), 64'h0);
            if (k == 0) begin
                check_eq("sp_tkeep", 64'(m_tkeep[0]), 64'hFF);
                check_eq("sp_tuser", 64'(m_tuser[0]), 64'h3);
            end
            cyc();
        end
        s0_tvalid = 1'b0;
        s0_tlast  = 1'b0;
        #1;
        check_eq("sp_ack_end", 64'(ack[0]),   64'h0);
        check_eq("sp_pkt0",    64'(pkt0[0]),  64'h1);
        check_eq("sp_tdata0",  m_tdata[0],    64'h0);

        // Round robin, 2-beat packets, both requesting
        apply_reset();
        req = 2'b11;
        #1;
        check_eq("rr_idle", 64'(ack[0]), 64'h0);
        cyc();
        for (int k = 0; k < 8; k++) begin
            int p;
            p = (k / 2) % 2;
            s0_tvalid = 1'b1;
            s1_tvalid = 1'b1;
            s0_tlast  = ((k % 2) != 0);
            s1_tlast  = ((k % 2) != 0);
            s0_tdata  = 64'hA0 + 64'(k);
            s1_tdata  = 64'hB0 + 64'(k);
            if (k == 7) req = 2'b00;
            #1;
            check_eq("rr_ack",   64'(ack[0]), (p != 0) ? 64'h2 : 64'h1);
            check_eq("rr_tdata", m_tdata[0],  (p != 0) ? (64'hB0 + 64'(k)) : (64'hA0 + 64'(k)));
            cyc();
        end
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        s0_tlast  = 1'b0;
        s1_tlast  = 1'b0;
        #1;
        check_eq("rr_pkt0", 64'(pkt0[0]), 64'h2);
        check_eq("rr_pkt1", 64'(pkt1[0]), 64'h2);
        check_eq("rr_end",  64'(ack[0]),  64'h0);

        // Backpressure on port 1 for 10 cycles, default watchdog
        apply_reset();
        req = 2'b10;
        cyc();
        s1_tvalid = 1'b1;
        s1_tdata  = 64'hC0;
        #1;
        check_eq("bp_beat0", 64'(m_tvalid[0]), 64'h1);
        cyc();
        s1_tdata = 64'hC1;
        tready   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("bp_s1rdy",  64'(s1_tready[0]), 64'h0);
            check_eq("bp_tvalid", 64'(m_tvalid[0]),  64'h1);
            check_eq("bp_tdata",  m_tdata[0],        64'hC1);
            check_eq("bp_ack",    64'(ack[0]),       64'h2);
            cyc();
        end
        tready   = 1'b1;
        s1_tlast = 1'b1;
        req      = 2'b00;
        #1;
        check_eq("bp_s1rdy_on", 64'(s1_tready[0]), 64'h1);
        cyc();
        s1_tvalid = 1'b0;
        s1_tlast  = 1'b0;
        #1;
        check_eq("bp_pkt1", 64'(pkt1[0]), 64'h1);
        check_eq("bp_tmo",  64'(tmo[0]),  64'h0);
        check_eq("bp_end",  64'(ack[0]),  64'h0);

        // Watchdog with TIMEOUT_CYCLES=8 (instance 1)
        apply_reset();
        req = 2'b01;
        cyc();
        s0_tvalid = 1'b1;
        tready    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("to_ack", 64'(ack[1]), 64'h1);
            cyc();
        end
        check_eq("to_release", 64'(ack[1]),  64'h0);
        check_eq("to_cnt",     64'(tmo[1]),  64'h1);
        check_eq("to_pkt0",    64'(pkt0[1]), 64'h0);
        req = 2'b11;
        cyc();
        check_eq("to_rr_next", 64'(ack[1]), 64'h2);
        req       = 2'b00;
        s0_tvalid = 1'b0;
        tready    = 1'b1;
        cyc();
        check_eq("to_withdraw", 64'(ack[1]), 64'h0);

        // Port 0 withdraws before any beat
        apply_reset();
        req = 2'b01;
        cyc();
        req = 2'b00;
        #1;
        check_eq("wd_ack", 64'(ack[0]), 64'h1);
        cyc();
        check_eq("wd_idle", 64'(ack[0]),  64'h0);
        check_eq("wd_pkt0", 64'(pkt0[0]), 64'h0);
        check_eq("wd_tmo",  64'(tmo[0]),  64'h0);

        // Link drop after one beat of port 1
        apply_reset();
        req = 2'b10;
        cyc();
        s1_tvalid = 1'b1;
        s1_tdata  = 64'hE0;
        #1;
        check_eq("ld_beat", 64'(m_tvalid[0]), 64'h1);
        cyc();
        lnk       = 1'b0;
        s1_tvalid = 1'b0;
        #1;
        check_eq("ld_still", 64'(ack[0]), 64'h2);
        cyc();
        check_eq("ld_idle", 64'(ack[0]), 64'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("ld_hold", 64'(ack[0]), 64'h0);
        end
        lnk = 1'b1;
        cyc();
        check_eq("ld_regrant", 64'(ack[0]),  64'h2);
        check_eq("ld_pkt1",    64'(pkt1[0]), 64'h0);
        check_eq("ld_tmo",     64'(tmo[0]),  64'h0);
        req = 2'b00;
        cyc();
        check_eq("ld_end", 64'(ack[0]), 64'h0);

        // tlast on the 4th granted cycle with TIMEOUT_CYCLES=4 (instance 2)
        apply_reset();
        req = 2'b01;
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("co_ack", 64'(ack[2]), 64'h1);
            cyc();
        end
        s0_tvalid = 1'b1;
        s0_tlast  = 1'b1;
        s0_tdata  = 64'hF0;
        req       = 2'b00;
        #1;
        check_eq("co_ack4", 64'(ack[2]), 64'h1);
        cyc();
        s0_tvalid = 1'b0;
        s0_tlast  = 1'b0;
        #1;
        check_eq("co_pkt0", 64'(pkt0[2]), 64'h1);
        check_eq("co_tmo",  64'(tmo[2]),  64'h0);
        check_eq("co_idle", 64'(ack[2]),  64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
